// File: rtl/sram_word_port.sv
// 32-bit word port in front of a 16-bit Avalon-MM SRAM controller.
// Splits each word request into LO/HI halfword commands and reassembles read returns.
module sram_word_port #(
  parameter int ADDR_W  = 19,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_be,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W:0]   address,
  output logic [1:0]        byteenable,
  output logic              read,
  output logic              write,
  output logic [15:0]       writedata,
  input  logic [15:0]       readdata,
  input  logic              readdatavalid
);

  localparam int WCW = $clog2(TIMEOUT + 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, LO, HI, WAIT_RD} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [3:0]        be;
  } req_t;

  state_t         state, state_nxt;
  req_t           req_q, src;
  logic [1:0]     rx_cnt;
  logic [WCW-1:0] wait_cnt;
  logic [31:0]    rx_buf, rx_buf_nxt;
  logic           accept, rx_take, rd_done, rd_tmo;
  logic           cmd_rd, cmd_wr;
  logic [ADDR_W:0] cmd_addr;
  logic [1:0]     cmd_be;
  logic [15:0]    cmd_wd;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid & req_ready;

  // On the accept edge the captured register is not loaded yet, so commands
  // and next-state decisions look straight at the request inputs.
  always_comb begin
    src = req_q;
    if (accept) src = '{we: req_we, addr: req_addr, wdata: req_wdata, be: req_be};
  end

  assign rx_take = readdatavalid & ~req_q.we & (state != IDLE) & (rx_cnt != 2'd2);
  assign rd_done = ~req_q.we & ((state == HI) | (state == WAIT_RD)) &
                   ((rx_cnt == 2'd2) | (rx_take & (rx_cnt == 2'd1)));
  assign rd_tmo  = (state == WAIT_RD) & ~rd_done & (wait_cnt == WAIT_LAST);

  always_comb begin
    rx_buf_nxt = rx_buf;
    if (rx_take && rx_cnt == 2'd0) rx_buf_nxt[15:0]  = readdata;
    if (rx_take && rx_cnt == 2'd1) rx_buf_nxt[31:16] = readdata;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Write halves with no byte enables are skipped without spending a cycle.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) begin
        if (!src.we)               state_nxt = LO;
        else if (src.be[1:0] != 0) state_nxt = LO;
        else if (src.be[3:2] != 0) state_nxt = HI;
        else                       state_nxt = IDLE;
      end
      LO:      state_nxt = (!src.we || src.be[3:2] != 0) ? HI : IDLE;
      HI:      state_nxt = (src.we || rd_done) ? IDLE : WAIT_RD;
      WAIT_RD: state_nxt = (rd_done || rd_tmo) ? IDLE : WAIT_RD;
      default: state_nxt = IDLE;
    endcase
  end

  // Command to be driven in the cycle where state_nxt becomes current.
  always_comb begin
    cmd_rd   = 1'b0;
    cmd_wr   = 1'b0;
    cmd_addr = '0;
    cmd_be   = '0;
    cmd_wd   = '0;
    unique case (state_nxt)
      LO: begin
        cmd_addr = {src.addr, 1'b0};
        if (src.we) begin
          cmd_wr = 1'b1;
          cmd_be = src.be[1:0];
          cmd_wd = src.wdata[15:0];
        end else begin
          cmd_rd = 1'b1;
          cmd_be = 2'b11;
        end
      end
      HI: begin
        cmd_addr = {src.addr, 1'b1};
        if (src.we) begin
          cmd_wr = 1'b1;
          cmd_be = src.be[3:2];
          cmd_wd = src.wdata[31:16];
        end else begin
          cmd_rd = 1'b1;
          cmd_be = 2'b11;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_q      <= '0;
      rx_cnt     <= '0;
      wait_cnt   <= '0;
      rx_buf     <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      read       <= 1'b0;
      write      <= 1'b0;
      address    <= '0;
      byteenable <= '0;
      writedata  <= '0;
    end else begin
      read       <= cmd_rd;
      write      <= cmd_wr;
      address    <= cmd_addr;
      byteenable <= cmd_be;
      writedata  <= cmd_wd;
      if (accept) req_q <= src;
      rx_cnt   <= accept ? 2'd0 : (rx_take ? rx_cnt + 2'd1 : rx_cnt);
      rx_buf   <= accept ? 32'd0 : rx_buf_nxt;
      wait_cnt <= (state == WAIT_RD && state_nxt == WAIT_RD) ? wait_cnt + 1'b1 : '0;
      resp_valid <= rd_done | rd_tmo;
      // Timeout reports whatever halves have landed; missing ones stay zero.
      if (rd_done || rd_tmo) begin
        resp_rdata <= rx_buf_nxt;
        resp_err   <= ~rd_done;
      end
    end
  end

endmodule

// File: tb/tb_sram_word_port.sv
// Scoreboard bench for sram_word_port: driver pushes expected SRAM commands and
// read responses, a negedge monitor pops and compares them, an SRAM model answers reads.
module tb_sram_word_port;
  localparam int TMO = 15;

  logic        clk = 0, reset;
  logic        req_valid, req_ready, req_we;
  logic [18:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [19:0] address;
  logic [1:0]  byteenable;
  logic        read, write;
  logic [15:0] writedata, readdata;
  logic        readdatavalid;

  sram_word_port #(.ADDR_W(19), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .address(address), .byteenable(byteenable), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .readdatavalid(readdatavalid)
  );

  always #5 clk = ~clk;

  typedef struct {logic rd; logic wr; logic [19:0] addr; logic [1:0] be; logic [15:0] wd; int cyc;} cmd_t;
  typedef struct {logic [31:0] d; logic err; int cyc;} rsp_t;
  typedef struct {int due; logic [15:0] d;} ret_t;

  cmd_t cmdq[$];
  rsp_t rspq[$];
  ret_t retq[$];
  logic [15:0] ref_mem[int];
  logic [15:0] sram[int];
  int   cyc = 0, errors = 0, checks = 0;
  int   lat_cur = 2, drop_cur = 0;
  logic prev_rv = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] init_val(input int a);
    return 16'(a * 7) ^ 16'h5A3C;
  endfunction

  function automatic logic [15:0] ref_get(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic logic [15:0] sram_get(input int a);
    return sram.exists(a) ? sram[a] : init_val(a);
  endfunction

  // SRAM model: applies observed writes, answers reads lat_cur cycles later.
  always @(negedge clk) begin
    logic [15:0] v;
    readdatavalid = 0;
    readdata = 0;
    if (retq.size() > 0 && retq[0].due == cyc) begin
      readdatavalid = 1;
      readdata = retq[0].d;
      void'(retq.pop_front());
    end
    if (write) begin
      v = sram_get(int'(address));
      if (byteenable[0]) v[7:0]  = writedata[7:0];
      if (byteenable[1]) v[15:8] = writedata[15:8];
      sram[int'(address)] = v;
    end
    if (read && !(drop_cur == 2 || (drop_cur == 1 && address[0])))
      retq.push_back('{cyc + lat_cur, sram_get(int'(address))});
  end

  // Monitor
  always @(negedge clk) begin
    cmd_t e;
    rsp_t r;
    if (read || write) begin
      chk("rd_wr_excl", 64'(read & write), 0);
      if (cmdq.size() == 0) chk("cmd_unexpected", {read, write, address}, 0);
      else begin
        e = cmdq.pop_front();
        chk("cmd", {read, write, address, byteenable, write ? writedata : 16'h0},
                   {e.rd, e.wr, e.addr, e.be, e.wr ? e.wd : 16'h0});
        chk("cmd_cyc", 64'(cyc), 64'(e.cyc));
      end
    end
    if (resp_valid) begin
      chk("resp_gap", 64'(prev_rv), 0);
      if (rspq.size() == 0) chk("resp_unexpected", {resp_err, resp_rdata}, 64'h1_0000_0000_0);
      else begin
        r = rspq.pop_front();
        chk("resp", {resp_err, resp_rdata}, {r.err, r.d});
        chk("resp_cyc", 64'(cyc), 64'(r.cyc));
      end
    end
    prev_rv = resp_valid;
  end

  task automatic wait_ready();
    for (int i = 0; i < 60; i++) begin
      if (req_ready) return;
      @(negedge clk);
    end
    chk("ready_timeout", 64'(req_ready), 1);
  endtask

  task automatic push_cmds(input bit we, input logic [18:0] a, input logic [31:0] d,
                           input logic [3:0] be, input int A);
    int slot = A;
    if (!we) begin
      cmdq.push_back('{1'b1, 1'b0, {a, 1'b0}, 2'b11, 16'h0, A});
      cmdq.push_back('{1'b1, 1'b0, {a, 1'b1}, 2'b11, 16'h0, A + 1});
      return;
    end
    if (be[1:0] != 0) begin
      cmdq.push_back('{1'b0, 1'b1, {a, 1'b0}, be[1:0], d[15:0], slot});
      slot++;
    end
    if (be[3:2] != 0) cmdq.push_back('{1'b0, 1'b1, {a, 1'b1}, be[3:2], d[31:16], slot});
  endtask

  task automatic ref_write(input logic [18:0] a, input logic [31:0] d, input logic [3:0] be);
    for (int h = 0; h < 2; h++) begin
      int hw = int'(a) * 2 + h;
      logic [15:0] v = ref_get(hw);
      for (int b = 0; b < 2; b++)
        if (be[2*h+b]) v[8*b +: 8] = d[16*h + 8*b +: 8];
      ref_mem[hw] = v;
    end
  endtask

  task automatic do_req(input bit we, input logic [18:0] a, input logic [31:0] d,
                        input logic [3:0] be, input int lat, input int drop);
    int A, n;
    logic [15:0] lo, hi;
    wait_ready();
    lat_cur = lat;
    drop_cur = drop;
    A = cyc + 1;
    req_valid = 1; req_we = we; req_addr = a; req_wdata = d; req_be = be;
    push_cmds(we, a, d, be, A);
    if (we) ref_write(a, d, be);
    else begin
      lo = ref_get(int'(a) * 2);
      hi = ref_get(int'(a) * 2 + 1);
      if (drop == 0)      rspq.push_back('{{hi, lo}, 1'b0, A + 2 + lat});
      else if (drop == 1) rspq.push_back('{{16'h0, lo}, 1'b1, A + 2 + TMO});
      else                rspq.push_back('{32'h0, 1'b1, A + 2 + TMO});
    end
    @(negedge clk);
    req_valid = 0;
    if (we) begin
      n = int'(be[1:0] != 0) + int'(be[3:2] != 0);
      wait_ready();
      chk("wr_ready_cyc", 64'(cyc), 64'(A + n));
    end else wait_ready();
  endtask

  initial begin
    int A;
    reset = 1; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_be = 0;
    readdata = 0; readdatavalid = 0;
    repeat (3) @(negedge clk);
    chk("reset_state", {req_ready, resp_valid, resp_err, resp_rdata, read, write, address, byteenable, writedata},
                       {1'b1, 73'h0});
    reset = 0;
    @(negedge clk);

    do_req(1, 19'h00010, 32'hDEADBEEF, 4'b1111, 2, 0);
    do_req(1, 19'h7FFFF, 32'h12345678, 4'b1100, 2, 0);
    do_req(1, 19'h00020, 32'hCAFEF00D, 4'b0000, 2, 0);
    do_req(0, 19'h00010, 32'h0, 4'b0, 2, 0);
    do_req(0, 19'h00010, 32'h0, 4'b0, 1, 0);
    do_req(0, 19'h00010, 32'h0, 4'b0, 2, 1);
    do_req(0, 19'h7FFFF, 32'h0, 4'b0, 3, 0);

    // Reset during the HI cycle of a read; its returns land after reset.
    wait_ready();
    lat_cur = 2; drop_cur = 0;
    A = cyc + 1;
    req_valid = 1; req_we = 0; req_addr = 19'h00010; req_be = 0;
    push_cmds(0, 19'h00010, 32'h0, 4'b0, A);
    @(negedge clk);
    req_valid = 0;
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("post_reset", {req_ready, resp_valid, resp_err, resp_rdata, read, write, address, byteenable, writedata},
                      {1'b1, 73'h0});
    repeat (5) @(negedge clk);
    do_req(0, 19'h00010, 32'h0, 4'b0, 2, 0);

    for (int i = 0; i < 60; i++) begin
      logic [18:0] a;
      int sel = $urandom_range(0, 9);
      if (sel == 0)      a = 19'h7FFFF;
      else if (sel == 1) a = 19'h0;
      else               a = 19'h100 + 19'($urandom_range(0, 7));
      do_req(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
             $urandom_range(1, 5), ($urandom_range(0, 9) == 0) ? $urandom_range(1, 2) : 0);
    end

    repeat (10) @(negedge clk);
    chk("cmdq_drained", 64'(cmdq.size()), 0);
    chk("rspq_drained", 64'(rspq.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/sram_word_port.md
Name: sram_word_port

Overview:
- 32-bit word access port sitting directly upstream of the board SRAM controller (16-bit Avalon-MM slave, 20-bit halfword address, no waitrequest).
- Splits each 32-bit processor/accelerator request into two 16-bit SRAM transactions, low half first.
- Reassembles read data from readdatavalid returns and reports a timeout error when returns do not arrive.

Parameters:
- ADDR_W, 19, word address width; the SRAM halfword address is {req_addr, half}, ADDR_W+1 = 20 bits.
- TIMEOUT, 15, max cycles to wait in WAIT_RD for outstanding readdatavalid pulses before aborting.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid & req_ready at rising edge
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address
- req_wdata  in  32  write data; [15:0] low half, [31:16] high half
- req_be  in  4  byte enables; [1:0] low half, [3:2] high half
- resp_valid  out  1  one-cycle pulse, read result ready
- resp_rdata  out  32  read data, valid with resp_valid
- resp_err  out  1  timeout flag, valid with resp_valid
- address  out  20  to SRAM controller
- byteenable  out  2  to SRAM controller
- read  out  1  to SRAM controller
- write  out  1  to SRAM controller
- writedata  out  16  to SRAM controller
- readdata  in  16  from SRAM controller
- readdatavalid  in  1  from SRAM controller

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, port name reset.
- Reset values:
  - All outputs 0 except req_ready = 1.
  - State IDLE, counters 0.
  - Reset mid-operation aborts the transaction with no response.
  - readdatavalid arriving after reset is ignored.
- All SRAM-side outputs are registered. read and write are never both 1.
- States: IDLE, LO, HI, WAIT_RD.
- req_ready = 1 only in IDLE. Request fields are captured on accept.
- Accept at edge T; the LO command drives during cycle T+1 and the HI command during cycle T+2.
- Write:
  - LO issues write=1, address={addr,0}, byteenable=be[1:0], writedata=wdata[15:0] only if be[1:0] != 0.
  - HI issues write=1, address={addr,1}, byteenable=be[3:2], writedata=wdata[31:16] only if be[3:2] != 0.
  - Skipped halves consume no cycle: be=1100 issues only the HI command, in cycle T+1.
  - be=0000 returns to IDLE at T+1 with no SRAM activity.
  - Writes are posted: no resp_valid.
- Read:
  - Both halves are always issued (read=1, byteenable=11) in cycles T+1 and T+2, then state goes to WAIT_RD.
  - A 2-bit receive count increments on each readdatavalid in LO, HI or WAIT_RD. Returns may arrive as early as the cycle of the HI command.
  - 1st return goes to rdata[15:0]; 2nd return goes to rdata[31:16].
  - When count reaches 2: resp_valid=1, resp_err=0 in the following cycle, and state returns to IDLE in that same cycle (req_ready=1 with resp_valid).
  - readdatavalid in IDLE, or a 3rd pulse, is ignored.
- Timeout:
  - A wait counter clears on entering WAIT_RD and increments each WAIT_RD cycle without completion.
  - If it reaches TIMEOUT: resp_valid=1, resp_err=1, resp_rdata holds the halves received so far (unreceived halves 0), then state goes to IDLE.
- resp_valid is never high two consecutive cycles. resp_rdata and resp_err hold their value until the next response.
- Address arithmetic: halfword address = req_addr*2 + half. req_addr all-ones maps to 0xFFFFE / 0xFFFFF with no wrap.

Test Plan:
- Reset, then write addr=0x00010, wdata=0xDEADBEEF, be=1111 -> T+1: write=1, address=0x00020, writedata=0xBEEF, be=11; T+2: address=0x00021, writedata=0xDEAD; req_ready=1 again at T+3.
- Write be=1100, wdata=0x12345678, addr=0x7FFFF -> a single cycle at T+1: write=1, address=0xFFFFF, writedata=0x1234, byteenable=11; be=0000 -> no write pulse.
- Read addr=0x00010 with a model returning 0xBEEF then 0xDEAD, each 2 cycles after its command -> resp_valid one cycle after the 2nd return, resp_rdata=0xDEADBEEF, resp_err=0.
- Read with returns at latency 1 (first return during the HI cycle) -> resp_rdata correct, exactly one resp_valid pulse, read asserted exactly twice.
- Read where the model returns only 0xBEEF -> TIMEOUT=15 cycles after entering WAIT_RD: resp_valid=1, resp_err=1, resp_rdata=0x0000BEEF, then IDLE.
- Assert reset during the HI cycle of a read, then deliver 2 readdatavalid pulses -> outputs zero and req_ready=1 the cycle after reset; no resp_valid; the next read completes correctly.
